// File: rtl/ram_bist.sv
// March-free BIST for a single-port synchronous RAM: writes seed+i to every word, reads it back and counts mismatches.
// Optional macro RAM_BIST_INV_EN adds a second pass with the inverted pattern.
module ram_bist #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W+1:0] err_cnt,
    output logic [ADDR_W-1:0] err_addr,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [ADDR_W-1:0] LAST    = '1;
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
    localparam logic [ADDR_W+1:0] CNT_MAX = '1;

`ifdef RAM_BIST_INV_EN
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_WRI, S_RDI, S_DRAINI} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN} state_t;
`endif

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                cen_q, cen_d, wen_q, wen_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic                first_q, first_d;
    logic [ADDR_W+1:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

    logic                cmp_en, cmp_inv, finish_run;
    logic [ADDR_W-1:0]   cmp_idx;

    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                  input logic [ADDR_W-1:0] idx,
                                                  input logic inv);
        logic [DATA_W-1:0] p;
        p = s + DATA_W'(idx);
        return inv ? ~p : p;
    endfunction

    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        addr_d     = addr_q;
        cen_d      = 1'b0;
        wen_d      = 1'b0;
        din_d      = '0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        pass_d     = pass_q;
        first_d    = first_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        cmp_en     = 1'b0;
        cmp_inv    = 1'b0;
        cmp_idx    = addr_q;
        finish_run = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d    = S_WR;
                    seed_d     = seed;
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                    pass_d     = 1'b0;
                    first_d    = 1'b0;
                    busy_d     = 1'b1;
                    cen_d      = 1'b1;
                    wen_d      = 1'b1;
                    addr_d     = '0;
                    din_d      = pattern(seed, '0, 1'b0);
                end
            end
            S_WR: begin
                cen_d = 1'b1;
                if (addr_q == LAST) begin
                    state_d = S_RD;
                    addr_d  = '0;
                end else begin
                    wen_d  = 1'b1;
                    addr_d = addr_q + ONE;
                    din_d  = pattern(seed_q, addr_q + ONE, 1'b0);
                end
            end
            S_RD: begin
                // Read data lags the issued address by one cycle.
                cmp_en  = (addr_q != '0);
                cmp_idx = addr_q - ONE;
                if (addr_q == LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    cen_d  = 1'b1;
                    addr_d = addr_q + ONE;
                end
            end
            S_DRAIN: begin
                cmp_en = 1'b1;
`ifdef RAM_BIST_INV_EN
                state_d = S_WRI;
                cen_d   = 1'b1;
                wen_d   = 1'b1;
                addr_d  = '0;
                din_d   = pattern(seed_q, '0, 1'b1);
`else
                finish_run = 1'b1;
`endif
            end
`ifdef RAM_BIST_INV_EN
            S_WRI: begin
                cen_d = 1'b1;
                if (addr_q == LAST) begin
                    state_d = S_RDI;
                    addr_d  = '0;
                end else begin
                    wen_d  = 1'b1;
                    addr_d = addr_q + ONE;
                    din_d  = pattern(seed_q, addr_q + ONE, 1'b1);
                end
            end
            S_RDI: begin
                cmp_en  = (addr_q != '0);
                cmp_inv = 1'b1;
                cmp_idx = addr_q - ONE;
                if (addr_q == LAST) begin
                    state_d = S_DRAINI;
                end else begin
                    cen_d  = 1'b1;
                    addr_d = addr_q + ONE;
                end
            end
            S_DRAINI: begin
                cmp_en     = 1'b1;
                cmp_inv    = 1'b1;
                finish_run = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (cmp_en && (mem_dout != pattern(seed_q, cmp_idx, cmp_inv))) begin
            if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
            if (!first_q) begin
                err_addr_d = cmp_idx;
                first_d    = 1'b1;
            end
        end

        // Pass is judged on the count that already includes the final compare.
        if (finish_run) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            addr_d  = '0;
            pass_d  = (err_cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            seed_q     <= '0;
            addr_q     <= '0;
            cen_q      <= 1'b0;
            wen_q      <= 1'b0;
            din_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            first_q    <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            seed_q     <= seed_d;
            addr_q     <= addr_d;
            cen_q      <= cen_d;
            wen_q      <= wen_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            first_q    <= first_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;
    assign mem_cen  = cen_q;
    assign mem_wen  = wen_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;

endmodule

// File: doc/ram_bist.md
# ram_bist

Built-in self-test controller that drives the single-port 32x32 synchronous `ram` through its `cen`/`wen`/`addr`/`din`/`dout` interface.

- **Sequence:** on a start request it writes a seed-derived pattern to every word, then reads every word back and compares it against the expected value.
- **Report:** pass/fail, a mismatch count and the first failing address.
- **Position in the design:** sits between the top-level test logic and the RAM instance, as the initiator side of the RAM port.

## Interface
Parameters:
- `ADDR_W`, 5, RAM address width; depth = 2^ADDR_W words.
- `DATA_W`, 32, RAM data width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `seed`  in  DATA_W  pattern seed; captured on the accepted start edge.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at run completion.
- `pass`  out  1  high when the last completed run had zero mismatches.
- `err_cnt`  out  ADDR_W+2  mismatch count, saturating at all-ones.
- `err_addr`  out  ADDR_W  address of the first mismatch; 0 if none.
- `mem_cen`  out  1  RAM chip enable.
- `mem_wen`  out  1  RAM write enable; 1 = write, 0 = read.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_din`  out  DATA_W  RAM write data.
- `mem_dout`  in  DATA_W  RAM read data.

## Operation
RAM contract, which this block relies on:
- Write at the rising edge when `cen=1`, `wen=1`.
- Read when `cen=1`, `wen=0`: `dout` is registered at that edge and valid during the following cycle.

Pattern and comparison:
- Expected data for word i: `P(i) = seed + i`, mod 2^DATA_W, where i is zero-extended.
- Comparison is a full-width equality check.

States:
- **IDLE**
  - `mem_cen=0`, `busy=0`.
  - `start=1` at an edge: capture `seed`, clear `err_cnt`, `err_addr`, `pass`, and the first-error flag; go to WR.
- **WR**
  - `mem_cen=1`, `mem_wen=1`, `mem_addr=i`, `mem_din=P(i)`, for i = 0..DEPTH-1, one word per cycle.
  - After i = DEPTH-1, go to RD.
- **RD**
  - `mem_cen=1`, `mem_wen=0`, `mem_addr=i`, for i = 0..DEPTH-1.
  - Each cycle compares `mem_dout` against P(i-1) for the address issued in the previous cycle; there is no compare in the first RD cycle.
  - After i = DEPTH-1, go to DRAIN.
- **DRAIN**
  - `mem_cen=0`.
  - Compares word DEPTH-1.
  - Next state: IDLE, or WRI when `RAM_BIST_INV_EN` is defined.
- **IDLE entry from a run:** `done=1` for exactly that cycle; `pass = (err_cnt==0)`, using the final count including the DRAIN compare.

On each mismatch:
- `err_cnt` increments, saturating.
- The first mismatch of the run latches `err_addr`; later mismatches leave it unchanged.

Other rules:
- `start` while `busy` is ignored, with no queuing.
- `mem_din` is don't-care when `mem_wen=0`; drive 0.

## Timing
Reset values, applied on the edge where `rst=1`:
- State IDLE.
- `busy=0`, `done=0`, `pass=0`, `err_cnt=0`, `err_addr=0`.
- `mem_cen=0`, `mem_wen=0`, `mem_addr=0`, `mem_din=0`.

Run timing:
- All outputs are registered; start is accepted at edge E0.
- `busy` is high for cycles E0+1 .. E0+2·DEPTH+1, i.e. 65 cycles at DEPTH=32.
- `done` is high in cycle E0+2·DEPTH+2, with `busy=0` in that cycle.
- A new `start` is accepted in the `done` cycle.

Boundary conditions:
- **Reset mid-run:** the next cycle has `mem_cen=0` and all outputs at their reset values; no `done` pulse; `seed` is discarded.
- **Address wrap:** the counter stops at DEPTH-1 and never wraps to 0 within a phase.
- **Data wrap:** `seed + i` overflows modulo 2^DATA_W.
- **`err_cnt` saturation:** stays at 2^(ADDR_W+2)-1.

## Configuration
`RAM_BIST_INV_EN`:
- **Defined:** DRAIN is followed by a second pass.
  - WRI writes `~P(i)`.
  - RDI/DRAINI read back and compare against `~P(i)`, with the same timing rules as WR/RD/DRAIN.
  - `busy` lasts 4·DEPTH+2 cycles; `done` comes at E0+4·DEPTH+3.
  - `err_cnt` accumulates across both passes; `err_addr` holds the first mismatch of either pass.
- **Undefined:** the single true-pattern pass only; the WRI/RDI/DRAINI states are not compiled in.

## Test plan
1. Good RAM model, `seed=0x0000_0000`, start pulse at E0 -> `mem_din` for addr 5 is 0x0000_0005; `done` at E0+66; `pass=1`, `err_cnt=0`, `err_addr=0`.
2. RAM model with bit 3 of addr 5 stuck-at-0, `seed=0x0000_0008` -> `err_cnt=1`, `err_addr=5`, `pass=0`; with `RAM_BIST_INV_EN` defined, `err_cnt` is still 1, because the inverted pattern has bit 3 = 0 at addr 5.
3. `seed=0xFFFF_FFFF` -> written data: addr 0 = 0xFFFF_FFFF, addr 1 = 0x0000_0000, addr 31 = 0x0000_001E; `pass=1`.
4. `start` held high through a whole run -> exactly one run, then a second run begins at the `done` edge; `start` pulses at E0+10 during `busy` are ignored, and `done` still occurs at E0+66.
5. `rst` at E0+10 during WR -> next cycle `mem_cen=0`, `busy=0`, `err_cnt=0`, no `done` pulse; a fresh start completes normally with `pass=1`.
6. RAM model returning 0 for every read, `seed=0x1` -> all 32 compares fail, `err_cnt=32`, `err_addr=0`; with `RAM_BIST_INV_EN`, `err_cnt=64`.
